count_tracker: RTL and testbench

//   Receive-side monitor for the bouncing up/down counter stream (LO..HI..LO triangle).

---
 rtl/count_tracker.sv | 174 +++++++++++++++++
 tb/tb_count_tracker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_tracker.sv
// Receive-side checker for a bouncing LO..HI..LO counter stream: infers direction,
// pulses on peaks/troughs, counts periods and flags samples that break the +/-1 rule.
module count_tracker #(
    parameter int unsigned W      = 8,
    parameter int unsigned LO     = 0,
    parameter int unsigned HI     = 255,
    parameter int unsigned PCNT_W = 16,
    parameter int unsigned ECNT_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [W-1:0]      in_data,
    input  logic              clr,
    output logic              dir,
    output logic              locked,
    output logic              peak,
    output logic              trough,
    output logic              err,
    output logic              err_sticky,
    output logic [PCNT_W-1:0] period_cnt,
    output logic [ECNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {ACQ, SEED, UP, DOWN} state_t;

    // Two guard bits: one so prev+1 cannot wrap, one as a sign bit for range tests.
    localparam logic [W+1:0] LO_X  = (W+2)'(LO);
    localparam logic [W+1:0] HI_X  = (W+2)'(HI);
    localparam logic [W+1:0] ONE_X = (W+2)'(1);

    state_t              state_q, state_d;
    logic [W-1:0]        prev_q, prev_d;
    logic                dir_q, dir_d;
    logic                locked_q, locked_d;
    logic                peak_q, peak_d;
    logic                trough_q, trough_d;
    logic                err_q, err_d;
    logic                sticky_q, sticky_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [ECNT_W-1:0]   ecnt_q, ecnt_d;
    logic                period_inc;

    logic [W+1:0]        s_x, p_x, lo_diff, hi_diff;
    logic                in_range, is_inc, is_dec, at_hi, at_lo;

    always_comb begin
        s_x      = {2'b00, in_data};
        p_x      = {2'b00, prev_q};
        lo_diff  = s_x - LO_X;
        hi_diff  = HI_X - s_x;
        in_range = !lo_diff[W+1] && !hi_diff[W+1];
        is_inc   = (s_x == p_x + ONE_X);
        is_dec   = (s_x + ONE_X == p_x);
        at_hi    = (s_x == HI_X);
        at_lo    = (s_x == LO_X);
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        dir_d      = dir_q;
        peak_d     = 1'b0;
        trough_d   = 1'b0;
        err_d      = 1'b0;
        period_inc = 1'b0;
        if (in_valid) begin
            prev_d = in_data;
            if (!in_range) begin
                err_d   = (state_q == UP) || (state_q == DOWN);
                state_d = SEED;
            end else begin
                case (state_q)
                    ACQ: state_d = SEED;
                    SEED: begin
                        if (is_inc) begin
                            if (at_hi) begin
                                state_d = DOWN;
                                dir_d   = 1'b1;
                                peak_d  = 1'b1;
                            end else begin
                                state_d = UP;
                                dir_d   = 1'b0;
                            end
                        end else if (is_dec) begin
                            if (at_lo) begin
                                state_d  = UP;
                                dir_d    = 1'b0;
                                trough_d = 1'b1;
                            end else begin
                                state_d = DOWN;
                                dir_d   = 1'b1;
                            end
                        end
                    end
                    UP: begin
                        if (is_inc) begin
                            if (at_hi) begin
                                state_d = DOWN;
                                dir_d   = 1'b1;
                                peak_d  = 1'b1;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = SEED;
                        end
                    end
                    DOWN: begin
                        if (is_dec) begin
                            if (at_lo) begin
                                state_d    = UP;
                                dir_d      = 1'b0;
                                trough_d   = 1'b1;
                                period_inc = 1'b1;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = SEED;
                        end
                    end
                    default: state_d = ACQ;
                endcase
            end
        end
        locked_d = (state_d == UP) || (state_d == DOWN);

        // Clear overrides counters and sticky flag but leaves the pulses alone.
        if (clr) begin
            pcnt_d   = '0;
            ecnt_d   = '0;
            sticky_d = 1'b0;
        end else begin
            pcnt_d   = period_inc ? pcnt_q + PCNT_W'(1) : pcnt_q;
            ecnt_d   = (err_d && (ecnt_q != '1)) ? ecnt_q + ECNT_W'(1) : ecnt_q;
            sticky_d = sticky_q | err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ACQ;
            prev_q   <= '0;
            dir_q    <= 1'b0;
            locked_q <= 1'b0;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            pcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            pcnt_q   <= pcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign dir        = dir_q;
    assign locked     = locked_q;
    assign peak       = peak_q;
    assign trough     = trough_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign period_cnt = pcnt_q;
    assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_count_tracker.sv
// Bench for count_tracker: directed stream scenarios, a trend-based reference model
// compared every cycle, and literal expectations at the key points of each scenario.
module tb_count_tracker;

    localparam int LO = 0;
    localparam int HI = 255;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        clr = 1'b0;
    logic        dir, locked, peak, trough, err, err_sticky;
    logic [15:0] period_cnt;
    logic [7:0]  err_cnt;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    count_tracker #(.W(8), .LO(LO), .HI(HI), .PCNT_W(16), .ECNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .dir(dir), .locked(locked), .peak(peak), .trough(trough), .err(err),
        .err_sticky(err_sticky), .period_cnt(period_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: trend is +1/-1 while locked, 0 while acquiring.
    bit have_prev, m_dir, m_peak, m_trough, m_err, m_sticky;
    int m_prev, trend, m_pcnt, m_ecnt;

    always @(posedge clk) begin
        int s, d, prev_trend;
        if (!rstn) begin
            have_prev = 0; m_dir = 0; m_peak = 0; m_trough = 0; m_err = 0; m_sticky = 0;
            m_prev = 0; trend = 0; m_pcnt = 0; m_ecnt = 0;
        end else begin
            m_peak = 0; m_trough = 0; m_err = 0;
            if (in_valid) begin
                s = int'(in_data);
                prev_trend = trend;
                if (s < LO || s > HI) begin
                    if (trend != 0) m_err = 1;
                    trend = 0;
                    have_prev = 1;
                end else if (!have_prev) begin
                    have_prev = 1;
                end else begin
                    d = s - m_prev;
                    if (trend == 0) begin
                        if (d == 1 || d == -1) trend = d;
                    end else if (d != trend) begin
                        m_err = 1;
                        trend = 0;
                    end
                    if (trend == 1 && s == HI) begin
                        m_peak = 1;
                        trend = -1;
                    end else if (trend == -1 && s == LO) begin
                        m_trough = 1;
                        if (prev_trend == -1) m_pcnt = (m_pcnt + 1) % 65536;
                        trend = 1;
                    end
                    if (trend != 0) m_dir = (trend == -1);
                end
                m_prev = s;
                if (m_err && m_ecnt < 255) m_ecnt++;
                m_sticky = m_sticky | m_err;
            end
            if (clr) begin
                m_pcnt = 0; m_ecnt = 0; m_sticky = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dir",        int'(dir),        int'(m_dir));
            chk("locked",     int'(locked),     (trend != 0) ? 1 : 0);
            chk("peak",       int'(peak),       int'(m_peak));
            chk("trough",     int'(trough),     int'(m_trough));
            chk("err",        int'(err),        int'(m_err));
            chk("err_sticky", int'(err_sticky), int'(m_sticky));
            chk("period_cnt", int'(period_cnt), m_pcnt);
            chk("err_cnt",    int'(err_cnt),    m_ecnt);
        end
    end

    task automatic put(input bit v, input int d, input bit c);
        in_valid = v;
        in_data  = 8'(d);
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic ramp(input int a, input int b, input bit gaps);
        int step;
        step = (b >= a) ? 1 : -1;
        for (int v = a; ; v += step) begin
            if (gaps) put(0, 77, 0);
            put(1, v, 0);
            if (v == b) break;
        end
    endtask

    task automatic do_reset(input bit v, input int d);
        rstn = 0; in_valid = v; in_data = 8'(d); clr = 0;
        @(posedge clk);
        #1;
        rstn = 1; in_valid = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dir"},    int'(dir), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_pulses"}, int'({peak, trough, err}), 0);
        chk({tag, "_sticky"}, int'(err_sticky), 0);
        chk({tag, "_pcnt"},   int'(period_cnt), 0);
        chk({tag, "_ecnt"},   int'(err_cnt), 0);
    endtask

    initial begin
        @(posedge clk);
        do_reset(0, 0);
        chk_en = 1;
        chk_all_zero("reset");

        // 1: one full triangle
        put(1, 0, 0);   chk("t1_locked_first", int'(locked), 0);
        put(1, 1, 0);   chk("t1_locked_second", int'(locked), 1);
                        chk("t1_dir_up", int'(dir), 0);
        ramp(2, 254, 0);
        chk("t1_no_early_peak", int'(peak), 0);
        put(1, 255, 0); chk("t1_peak", int'(peak), 1);
                        chk("t1_dir_down", int'(dir), 1);
        ramp(254, 1, 0);
        put(1, 0, 0);   chk("t1_trough", int'(trough), 1);
                        chk("t1_pcnt", int'(period_cnt), 1);
                        chk("t1_ecnt", int'(err_cnt), 0);

        // 2: two triangles with in_valid gaps
        do_reset(0, 0);
        ramp(0, 255, 1);
        chk("t2_peak", int'(peak), 1);
        put(0, 3, 0);
        chk("t2_gap_peak", int'(peak), 0);
        chk("t2_gap_dir", int'(dir), 1);
        chk("t2_gap_locked", int'(locked), 1);
        ramp(254, 0, 1);
        ramp(1, 255, 1);
        ramp(254, 0, 1);
        chk("t2_trough", int'(trough), 1);
        chk("t2_pcnt", int'(period_cnt), 2);
        chk("t2_ecnt", int'(err_cnt), 0);

        // 3: skip in UP, then relock
        do_reset(0, 0);
        ramp(0, 10, 0);
        put(1, 12, 0);  chk("t3_err", int'(err), 1);
                        chk("t3_ecnt", int'(err_cnt), 1);
                        chk("t3_sticky", int'(err_sticky), 1);
                        chk("t3_unlocked", int'(locked), 0);
        put(1, 13, 0);  chk("t3_relock", int'(locked), 1);
        put(1, 14, 0);  chk("t3_no_err", int'(err), 0);
                        chk("t3_ecnt_hold", int'(err_cnt), 1);

        // 4: stall, skipped turnaround, 9-bit compare at the top of the range
        do_reset(0, 0);
        ramp(95, 100, 0);
        put(1, 100, 0); chk("t4_stall_err", int'(err), 1);
        ramp(250, 254, 0);
        put(1, 253, 0); chk("t4_skip_err", int'(err), 1);
                        chk("t4_skip_no_peak", int'(peak), 0);
                        chk("t4_ecnt", int'(err_cnt), 2);
        put(1, 255, 0);
        put(1, 0, 0);   chk("t4_no_wrap_lock", int'(locked), 0);
        put(1, 254, 0);
        put(1, 255, 0); chk("t4_seed_peak", int'(peak), 1);
                        chk("t4_seed_peak_dir", int'(dir), 1);

        // 5: seed downwards, trough counting rules
        do_reset(0, 0);
        put(1, 5, 0);
        put(1, 4, 0);   chk("t5_down", int'(dir), 1);
        ramp(3, 0, 0);  chk("t5_trough", int'(trough), 1);
                        chk("t5_dir", int'(dir), 0);
                        chk("t5_pcnt", int'(period_cnt), 1);
        put(1, 7, 0);
        put(1, 1, 0);
        put(1, 0, 0);   chk("t5_seed_trough", int'(trough), 1);
                        chk("t5_pcnt_same", int'(period_cnt), 1);

        // 6: saturation, clear, reset mid-stream
        do_reset(0, 0);
        put(1, 0, 0);
        put(1, 1, 0);
        for (int i = 0; i < 150; i++) begin
            put(1, 50, 0); put(1, 51, 0); put(1, 10, 0); put(1, 11, 0);
        end
        chk("t6_ecnt_sat", int'(err_cnt), 255);
        chk("t6_sticky", int'(err_sticky), 1);
        put(0, 0, 1);   chk("t6_clr_ecnt", int'(err_cnt), 0);
                        chk("t6_clr_sticky", int'(err_sticky), 0);
                        chk("t6_clr_locked", int'(locked), 1);
                        chk("t6_clr_dir", int'(dir), 0);
        put(1, 200, 1); chk("t6_clr_err_pulse", int'(err), 1);
                        chk("t6_clr_err_ecnt", int'(err_cnt), 0);
        put(1, 201, 0);
        ramp(202, 205, 0);
        do_reset(1, 206);
        chk_all_zero("t6_midreset");
        put(1, 207, 0); chk("t6_acq_locked", int'(locked), 0);
        put(1, 208, 0); chk("t6_relock", int'(locked), 1);

        put(0, 0, 0);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
